// File: rtl/ram_arbiter_2p_if.sv
// Client-side bus of the two-port RAM arbiter: request fields in, ack and read data out.
interface ram_arbiter_2p_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata0, rdata1
  );
endinterface

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter that serialises two clients onto one single-port RAM.
// Writes take WR->ACK, reads take RD0->RD1->ACK; one access in flight at a time.
module ram_arbiter_2p #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_arbiter_2p_if.slave     bus,
  output logic                busy,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_wr,
  output logic                ram_re,
  inout  wire  [DW-1:0]       ram_d
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD0,
    S_RD1,
    S_ACK
  } state_t;

  state_t        r_state;
  logic          r_ptr;
  logic          r_gnt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  logic [1:0]    w_req;
  logic [1:0]    w_we;
  logic [AW-1:0] w_addr  [2];
  logic [DW-1:0] w_wdata [2];
  logic          w_any;
  logic          w_win;
  logic          w_wr;
  logic          w_rd;

  assign w_req      = {bus.req1, bus.req0};
  assign w_we       = {bus.we1, bus.we0};
  assign w_addr[0]  = bus.addr0;
  assign w_addr[1]  = bus.addr1;
  assign w_wdata[0] = bus.wdata0;
  assign w_wdata[1] = bus.wdata1;

  // A lone requester always wins; under contention the pointer decides.
  assign w_any = |w_req;
  assign w_win = (&w_req) ? r_ptr : w_req[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_gnt   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_win;
            r_addr  <= w_addr[w_win];
            r_wdata <= w_wdata[w_win];
            r_state <= w_we[w_win] ? S_WR : S_RD0;
          end
        end
        S_WR: begin
          r_state <= S_ACK;
          r_ptr   <= ~r_gnt;
        end
        S_RD0: begin
          r_state <= S_RD1;
        end
        S_RD1: begin
          r_state <= S_ACK;
          r_ptr   <= ~r_gnt;
        end
        S_ACK: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Per-client completion pulse and read-data holding register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_client
      logic          r_ack;
      logic [DW-1:0] r_rdata;
      logic          w_mine;

      assign w_mine = (r_gnt == 1'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ack   <= 1'b0;
          r_rdata <= '0;
        end else begin
          r_ack <= w_mine && ((r_state == S_WR) || (r_state == S_RD1));
          if (w_mine && (r_state == S_RD1)) begin
            r_rdata <= ram_d;
          end
        end
      end
    end
  endgenerate

  assign bus.ack0   = g_client[0].r_ack;
  assign bus.ack1   = g_client[1].r_ack;
  assign bus.rdata0 = g_client[0].r_rdata;
  assign bus.rdata1 = g_client[1].r_rdata;

  assign w_wr     = (r_state == S_WR);
  assign w_rd     = (r_state == S_RD0) || (r_state == S_RD1);
  assign busy     = (r_state != S_IDLE);
  assign ram_wr   = w_wr;
  assign ram_re   = w_rd;
  assign ram_addr = (w_wr || w_rd) ? r_addr : '0;
  assign ram_d    = w_wr ? r_wdata : 'z;

endmodule
